hidden_to_output_neuron: RTL and testbench
==========================================

# hidden_to_output_neuron

Sequential output-layer neuron. It consumes the 8-bit hidden-layer activation vector, one bit per hidden perceptron, produced by the thresholded perceptron array. It computes a weighted sum of those bits plus a bias, serially over 8 cycles. It then presents the score and a fire/no-fire decision through a valid/ready handshake, which gives the network its second layer without eight parallel adders.

## Interface
Parameters:
- `WEIGHTS`, default 64'h0807060504030201. Eight unsigned 8-bit weights. `WEIGHTS[8*i+7:8*i]` applies to `in_bits[i]`.
- `BIAS`, default 8'd0. Unsigned 8-bit bias, preloaded into the accumulator.
- `THRESH`, default 12'd16. Unsigned 12-bit firing threshold.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: `in_bits` is valid.
- `in_ready`, out, 1: block can accept a vector.
- `in_bits`, in, 8: hidden-layer activation bits.
- `out_valid`, out, 1: result is valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_score`, out, 12: BIAS + Σ `in_bits[i]`·W[i], unsigned.
- `out_fire`, out, 1: `out_score` ≥ `THRESH`.
- `busy`, out, 1: the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACC and DONE.
- IDLE:
  - `in_ready`=1 (forced 0 while `rst`=1).
  - On `in_valid`&`in_ready`: latch `in_bits` into an 8-bit shift register, set acc←BIAS (zero-extended), set idx←0, go to ACC.
  - `in_bits` is don't-care when no transfer occurs.
- ACC:
  - One weight per cycle, for idx = 0..7.
  - If the current bit is 1, acc←acc+W[idx]; otherwise acc is unchanged. idx increments.
  - A zero bit still costs its cycle, so latency is fixed.
  - On the idx=7 cycle: register `out_score`←final acc, `out_fire`←(final acc ≥ THRESH), `out_valid`←1, go to DONE.
- DONE:
  - Hold `out_valid`, `out_score` and `out_fire` stable.
  - On `out_valid`&`out_ready`: `out_valid`←0, go to IDLE.
  - `in_ready`=0, and `in_valid` is ignored.
- Arithmetic:
  - The accumulator is 12 bits unsigned. Maximum is 8·255+255 = 2295 < 4096, so no overflow or wrap is possible and no saturation logic is needed.
  - The comparison is unsigned, 12-bit, and inclusive.
- `out_score` and `out_fire` keep their last values after the output handshake until the next result overwrites them.
- `busy` is 1 in ACC and DONE.
- Inputs are captured once. Changes on `in_bits` after acceptance do not affect the running computation.

## Timing
- Reset: while `rst`=1 at an edge, the next state is IDLE, with `out_valid`=0, `out_score`=0, `out_fire`=0, `busy`=0, acc=0 and idx=0. `in_ready` is 0 during the `rst`=1 cycle and 1 in the first cycle after.
- Latency: the accept handshake is sampled at the end of cycle 0. ACC occupies cycles 1–8. `out_valid` is high from cycle 9.
- `in_ready` is combinational from state (and `rst`). `out_valid` is registered.
- Throughput: with `out_ready` held at 1, the output handshake completes in cycle 9, IDLE is reached in cycle 10, and the next accept can happen in cycle 10. Minimum period is 10 cycles per vector.
- Backpressure: DONE persists indefinitely while `out_ready`=0, and no new input is accepted.
- Reset mid-operation: `rst` in any ACC or DONE cycle aborts the computation. No partial result is ever flagged valid, and the pending result is discarded.
- Simultaneous `rst` and a handshake: reset wins and no transfer occurs.

## Test plan
- Defaults, `in_bits`=8'hFF accepted at cycle 0, `out_ready`=1 → `out_valid` rises at cycle 9 with `out_score`=36 and `out_fire`=1; `in_ready`=1 again at cycle 10.
- Defaults, `in_bits`=8'h0F → `out_score`=10 and `out_fire`=0. Then back-to-back 8'hF0 accepted at cycle 10 → `out_score`=26 and `out_fire`=1 at cycle 19.
- Threshold edge: `THRESH`=8, `in_bits`=8'h80 → `out_score`=8 and `out_fire`=1. With `in_bits`=8'h40 → 7 and `out_fire`=0. With `in_bits`=8'h00 and `BIAS`=8'd5 → 5 and `out_fire`=0.
- Max range: `WEIGHTS` all 8'hFF, `BIAS`=8'hFF, `THRESH`=12'd2295, `in_bits`=8'hFF → `out_score`=2295 and `out_fire`=1, with no wrap.
- Backpressure: result 36 ready, hold `out_ready`=0 for 5 cycles while toggling `in_valid`/`in_bits` → `out_valid`, `out_score` and `out_fire` stay constant, `in_ready`=0, and nothing is accepted. Raising `out_ready` → IDLE on the next cycle.
- Reset abort: accept 8'hFF, assert `rst` in cycle 4 for one cycle → cycle 5 is IDLE with `out_valid`=0 and `busy`=0, `out_score`=0, and no result is ever emitted for that vector. A following 8'h01 → `out_score`=1.

Source files
------------

// File: rtl/hidden_to_output_neuron.sv
// hidden_to_output_neuron: serial weighted sum of 8 hidden bits plus bias, thresholded, valid/ready output
module hidden_to_output_neuron #(
  parameter logic [63:0] WEIGHTS = 64'h0807060504030201,
  parameter logic [7:0]  BIAS    = 8'd0,
  parameter logic [11:0] THRESH  = 12'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_bits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_score,
  output logic        out_fire,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t      state;
  logic [7:0]  bits;
  logic [2:0]  idx;
  logic [11:0] acc;
  logic [11:0] sum;
  logic [7:0]  w;
  assign w        = WEIGHTS[8*idx +: 8];
  // bits shifts right each cycle, so bit 0 always lines up with W[idx]
  assign sum      = acc + (bits[0] ? {4'd0, w} : 12'd0);
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bits      <= '0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_score <= '0;
      out_fire  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bits  <= in_bits;
          acc   <= {4'd0, BIAS};
          idx   <= '0;
          state <= ACC;
        end
        ACC: begin
          acc  <= sum;
          bits <= bits >> 1;
          idx  <= idx + 3'd1;
          if (idx == 3'd7) begin
            out_score <= sum;
            out_fire  <= sum >= THRESH;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hidden_to_output_neuron.sv
// tb_hidden_to_output_neuron: four parameterisations share stimulus; scoreboard of expected scores per accepted vector
module tb_hidden_to_output_neuron;
  localparam logic [63:0] W [4] = '{64'h0807060504030201, 64'h0807060504030201, 64'h0807060504030201, {8{8'hFF}}};
  localparam logic [7:0]  B [4] = '{8'd0, 8'd0, 8'd5, 8'hFF};
  localparam logic [11:0] T [4] = '{12'd16, 12'd8, 12'd8, 12'd2295};
  typedef logic [3:0][11:0] exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_bits = 8'h00;
  logic        out_ready = 1'b1;
  logic        ir [4];
  logic        ov [4];
  logic [11:0] sc [4];
  logic        fi [4];
  logic        bz [4];
  exp_t        sb [$];
  int          passed = 0;
  int          total = 0;
  always #5 clk = ~clk;
  hidden_to_output_neuron #(.WEIGHTS(W[0]), .BIAS(B[0]), .THRESH(T[0])) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_bits(in_bits), .out_valid(ov[0]), .out_ready(out_ready), .out_score(sc[0]), .out_fire(fi[0]), .busy(bz[0]));
  hidden_to_output_neuron #(.WEIGHTS(W[1]), .BIAS(B[1]), .THRESH(T[1])) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_bits(in_bits), .out_valid(ov[1]), .out_ready(out_ready), .out_score(sc[1]), .out_fire(fi[1]), .busy(bz[1]));
  hidden_to_output_neuron #(.WEIGHTS(W[2]), .BIAS(B[2]), .THRESH(T[2])) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_bits(in_bits), .out_valid(ov[2]), .out_ready(out_ready), .out_score(sc[2]), .out_fire(fi[2]), .busy(bz[2]));
  hidden_to_output_neuron #(.WEIGHTS(W[3]), .BIAS(B[3]), .THRESH(T[3])) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_bits(in_bits), .out_valid(ov[3]), .out_ready(out_ready), .out_score(sc[3]), .out_fire(fi[3]), .busy(bz[3]));
  function automatic logic [11:0] model(logic [63:0] w, logic [7:0] b, logic [7:0] x);
    logic [11:0] s = {4'd0, b};
    for (int i = 0; i < 8; i++) if (x[i]) s = s + {4'd0, w[8*i +: 8]};
    return s;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] x);
    exp_t e;
    for (int i = 0; i < 4; i++) e[i] = model(W[i], B[i], x);
    sb.push_back(e);
    in_valid = 1'b1;
    in_bits  = x;
    tick();
    in_valid = 1'b0;
    in_bits  = 8'($urandom);
    chk("busy_after_accept", bz[0], 1);
  endtask
  task automatic collect();
    int   n = 1;
    exp_t e;
    while (!ov[0] && n < 30) begin
      in_bits = 8'($urandom);
      tick();
      n++;
    end
    chk("latency", n, 9);
    if (sb.size() == 0) chk("sb_nonempty", 0, 1);
    else begin
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid%0d", i), ov[i], 1);
        chk($sformatf("score%0d", i), sc[i], e[i]);
        chk($sformatf("fire%0d", i), fi[i], e[i] >= T[i]);
      end
    end
  endtask
  task automatic release_out();
    tick();
    chk("valid_drop", ov[0], 0);
    chk("in_ready_back", ir[0], 1);
  endtask
  initial begin
    int seen;
    tick();
    chk("rst_in_ready", ir[0], 0);
    tick();
    chk("rst_valid", ov[0], 0);
    chk("rst_score", sc[0], 0);
    chk("rst_fire", fi[0], 0);
    chk("rst_busy", bz[0], 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", ir[0], 1);
    send(8'hFF);
    collect();
    chk("ff_score_36", sc[0], 36);
    chk("ff_fire", fi[0], 1);
    chk("max_2295", sc[3], 2295);
    release_out();
    chk("score_held", sc[0], 36);
    send(8'h0F);
    collect();
    chk("0f_score_10", sc[0], 10);
    chk("0f_fire", fi[0], 0);
    release_out();
    send(8'hF0);
    collect();
    chk("f0_score_26", sc[0], 26);
    release_out();
    send(8'h80);
    collect();
    chk("80_t8_score", sc[1], 8);
    chk("80_t8_fire", fi[1], 1);
    release_out();
    send(8'h40);
    collect();
    chk("40_t8_score", sc[1], 7);
    chk("40_t8_fire", fi[1], 0);
    release_out();
    send(8'h00);
    collect();
    chk("00_bias5_score", sc[2], 5);
    chk("00_bias5_fire", fi[2], 0);
    release_out();
    out_ready = 1'b0;
    send(8'hFF);
    collect();
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      in_bits  = 8'($urandom);
      tick();
      chk("bp_valid", ov[0], 1);
      chk("bp_score", sc[0], 36);
      chk("bp_fire", fi[0], 1);
      chk("bp_in_ready", ir[0], 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    release_out();
    tick();
    chk("bp_nothing_accepted", bz[0], 0);
    send(8'hFF);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    void'(sb.pop_front());
    chk("abort_valid", ov[0], 0);
    chk("abort_busy", bz[0], 0);
    chk("abort_score", sc[0], 0);
    chk("abort_in_ready", ir[0], 1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ov[0]) seen++;
    end
    chk("abort_no_result", seen, 0);
    send(8'h01);
    collect();
    chk("after_abort_score_1", sc[0], 1);
    release_out();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
